mem_requester: RTL

//  Initiator side of the memory-controller handshake. Accepts one command at a time (read or

---
 rtl/mem_requester.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_requester.sv
// mem_requester
//   Initiator side of the memory-controller handshake. Takes one command at a
//   time (read, or byte-strobed write) and presents it to mem_controller. It
//   then drives the BRAM address and write data, waits out the RAM read latency,
//   and returns a single response. Exactly one transaction is outstanding at any
//   time.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   S_IDLE   | ready for a command; nothing outstanding
//   S_REQ    | request asserted toward controller, waiting for ctrl_ready_i
//   S_ACC    | controller access cycle; enables and addr/wdata held
//   S_RDWAIT | read only: counting down RAM latency, capture on last cycle
//   S_RESP   | response presented until rsp_ready_i
//
// Ports
//   clk_i, rst_i                        clock / async active-high reset
//   cmd_valid_i/cmd_ready_o             command handshake
//   cmd_we_i/cmd_addr_i/cmd_wdata_i     command payload (we == 0 means read)
//   ctrl_ready_i                        controller idle
//   ctrl_read_en_o/ctrl_write_en_o      request toward controller
//   mem_addr_o/mem_wdata_o/mem_rdata_i  BRAM side
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_write_o/rsp_rdata_o             response payload
//   rd_cnt_o/wr_cnt_o                   saturating completed-transaction counts
module mem_requester #(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [3:0]            cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    input  logic                  ctrl_ready_i,
    output logic                  ctrl_read_en_o,
    output logic [3:0]            ctrl_write_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [31:0]           rsp_rdata_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACC,
        S_RDWAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [LAT_W-1:0]      lat_q;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, wr_cnt_q;
    logic                  is_write;

    assign is_write = (we_q != 4'b0000);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_ready_o     = 1'b0;
        ctrl_read_en_o  = 1'b0;
        ctrl_write_en_o = 4'b0000;
        rsp_valid_o     = 1'b0;
        rsp_write_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = S_REQ;
            end
            S_REQ: begin
                ctrl_read_en_o  = ~is_write;
                ctrl_write_en_o = we_q;
                if (ctrl_ready_i) state_d = S_ACC;
            end
            S_ACC: begin
                // Controller derives the RAM we combinationally from write_en,
                // so the enables must survive through the access cycle.
                ctrl_read_en_o  = ~is_write;
                ctrl_write_en_o = we_q;
                state_d         = is_write ? S_RESP : S_RDWAIT;
            end
            S_RDWAIT: begin
                if (lat_q == '0) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_write_o = is_write;
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            lat_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        we_q    <= cmd_we_i;
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        rdata_q <= '0;  // write acks report zero data
                    end
                end
                S_ACC: begin
                    lat_q <= LAT_W'(RD_LATENCY - 1);
                end
                S_RDWAIT: begin
                    if (lat_q == '0) rdata_q <= mem_rdata_i;
                    else             lat_q   <= lat_q - 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        if (is_write) begin
                            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
                        end else begin
                            if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;

endmodule
